// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO, circular buffer with
// registered read data, occupancy count and registered status flags.
// Ports: clk_w, reset (sync, active-low), wre/wrd write side,
//   rde/rdd read side (1-cycle latency), full, empty, almost_full,
//   almost_empty, level (0..DEPTH), ovf/udf sticky errors, clr_err.
// Optional: define FIFO_ERR_EN to build the sticky ovf/udf logic;
//   otherwise ovf/udf are tied low and clr_err is ignored.
module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic                       clk_w,
    input  logic                       reset,
    input  logic                       wre,
    input  logic [WIDTH-1:0]           wrd,
    input  logic                       rde,
    output logic [WIDTH-1:0]           rdd,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic                       udf,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic [AW:0]      level_nxt;
    logic             do_wr;
    logic             do_rd;

    // A write while full is only accepted when a read frees a slot
    // on the same edge.
    assign do_wr = wre & (~full | rde);
    assign do_rd = rde & ~empty;

    always_comb begin
        level_nxt = level_q;
        if (do_wr && !do_rd) begin
            level_nxt = level_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            level_nxt = level_q - 1'b1;
        end
    end

    // Storage is deliberately not reset. When full with a read and a
    // write on the same slot, the read below sees the old word.
    always_ff @(posedge clk_w) begin
        if (do_wr && reset) begin
            mem[wr_ptr] <= wrd;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_w) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            rdd          <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rdd    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q      <= level_nxt;
            // Flags come from the next level so they never lag.
            full         <= (level_nxt == LVL_FULL);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= LVL_AF);
            almost_empty <= (level_nxt <= LVL_AE);
        end
    end

    assign level = level_q;

`ifdef FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Set has priority over clear.
    always_ff @(posedge clk_w) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wre && full && !rde) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rde && empty) begin
                udf_q <= 1'b1;
            end else if (clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign ovf            = 1'b0;
    assign udf            = 1'b0;
`endif

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 3-entry byte FIFO.
- Adds configurable data width and depth, a circular buffer with read/write pointers, and an occupancy count output.
- Adds programmable almost-full/almost-empty flags and defined behaviour for every simultaneous read/write case, including read+write while full.
- Sits between byte/word producers and consumers in the ALU datapath, all clocked on clk_w.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AF_MARGIN, 1, almost_full asserts when level >= DEPTH-AF_MARGIN; range 0..DEPTH-1.
- AE_MARGIN, 1, almost_empty asserts when level <= AE_MARGIN; range 0..DEPTH-1.
- Derived: AW = clog2(DEPTH).

Ports:
- clk_w  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk_w.
- wre  input  1  write request.
- wrd  input  WIDTH  write data.
- rde  input  1  read request.
- rdd  output  WIDTH  read data, registered.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- almost_full  output  1  see AF_MARGIN.
- almost_empty  output  1  see AE_MARGIN.
- level  output  AW+1  current occupancy, 0..DEPTH.
- ovf  output  1  sticky overflow flag (FIFO_ERR_EN only).
- udf  output  1  sticky underflow flag (FIFO_ERR_EN only).
- clr_err  input  1  clears ovf/udf (FIFO_ERR_EN only).

Behaviour:
- Reset (reset==0 at a clk_w edge):
  - wr_ptr=0, rd_ptr=0, level=0, rdd=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_MARGIN==DEPTH-... evaluated at level 0, i.e. 0 unless DEPTH-AF_MARGIN==0, which the range forbids), so almost_full=0.
  - ovf=0, udf=0.
  - Memory contents are not reset.
  - Reset overrides wre/rde in the same cycle; a mid-stream reset discards all entries.
- Storage: mem[DEPTH] circular buffer; both pointers wrap from DEPTH-1 to 0.
- Write accept: do_wr = wre & (!full | rde). Data is stored at mem[wr_ptr], then wr_ptr increments.
- Read accept: do_rd = rde & !empty.
  - rdd <= mem[rd_ptr], then rd_ptr increments.
  - Read latency is 1 cycle: rdd is valid after the edge that accepts the read.
  - rdd holds its value when no read is accepted.
- Level update:
  - +1 when do_wr & !do_rd.
  - -1 when do_rd & !do_wr.
  - Unchanged otherwise.
- All flags are registered and computed from the next level value, so they are exact in the cycle after each edge (no lag).
- Boundary cases:
  - Empty, wre & rde: write accepted, read rejected, rdd holds, level becomes 1. No fall-through.
  - Full, wre & rde: both accepted. rdd takes the old mem[rd_ptr] (read-before-write on the shared slot); the new word goes into the freed slot. level stays DEPTH, full stays 1.
  - Full, wre & !rde: write dropped, pointers unchanged.
  - Empty, rde & !wre: read ignored, rdd holds.
  - Partially filled, wre & rde: both accepted, level unchanged.
- Data ordering is strict FIFO; no word is lost or duplicated except writes dropped while full.

Optional Feature:
- Macro FIFO_ERR_EN.
- Defined:
  - ovf sets on wre & full & !rde.
  - udf sets on rde & empty, including the empty-with-write case.
  - Both are sticky until clr_err==1 at an edge, or reset.
  - A set event coinciding with clr_err leaves the flag set (set wins).
- Undefined: ovf and udf are tied to 0, clr_err is ignored, and no error logic is synthesised.

Test Plan (WIDTH=8, DEPTH=4, AF_MARGIN=1, AE_MARGIN=1):
- Reset then idle → rdd=0x00, empty=1, full=0, level=0, almost_empty=1, almost_full=0.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles → level 1,2,3,4. almost_empty drops after level 2, almost_full rises at level 3, full=1 at level 4. A fifth write of 0x55 → dropped, level=4, ovf=1 (FIFO_ERR_EN).
- From full, wre&rde with wrd=0x55 → rdd=0x11, level=4, full=1. Then read 4 times → rdd=0x22,0x33,0x44,0x55, and empty=1 after the last read.
- From empty, wre&rde with wrd=0xA5 → rdd unchanged, level=1, udf=1 (FIFO_ERR_EN). Next cycle rde → rdd=0xA5, empty=1.
- Fill 2 entries, then 10 cycles of wre&rde with incrementing data → level stays 2, rdd sequence is in order, and pointers wrap without loss.
- Load 3 entries, assert reset=0 for one cycle with wre=1 → level=0, empty=1, rdd=0x00, ovf=udf=0. A subsequent write/read round-trips correctly.
